// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_fifo_ctrl : FIFO controller over a 1-cycle-read dual-port BRAM with a
//                  2-entry first-word-fall-through output buffer.
// Option macro   : BRAM_FIFO_BYPASS_EN (empty-FIFO words skip the BRAM)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] wr_addra,
  output logic [DATA_WIDTH-1:0] dia,
  output logic                  reb,
  output logic [ADDR_WIDTH-1:0] rd_addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam logic [ADDR_WIDTH:0]   c_depth     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH-1:0] r_rp;
  logic [ADDR_WIDTH:0]   r_mcnt;
  logic                  r_infl;
  logic [1:0]            r_ocnt;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;
  logic [ADDR_WIDTH+1:0] r_count;

  logic                  w_enq_fire;
  logic                  w_deq_fire;
  logic                  w_bypass;
  logic [2:0]            w_slots;
  logic [1:0]            w_ob_tail;
  logic                  w_ob_wr;
  logic [DATA_WIDTH-1:0] w_ob_word;
  logic [ADDR_WIDTH:0]   w_mcnt_nxt;
  logic [1:0]            w_ocnt_nxt;
  logic [ADDR_WIDTH+1:0] w_count_nxt;

  function automatic logic [ADDR_WIDTH-1:0] f_ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == c_last_addr) ? '0 : p + 1'b1;
  endfunction

  assign enq_ready = (r_mcnt != c_depth);
  assign deq_valid = (r_ocnt != 2'd0);
  assign deq_data  = r_ob0;
  assign wr_addra  = r_wp;
  assign rd_addrb  = r_rp;
  assign dia       = enq_data;
  assign count     = r_count;

  always_comb begin
    w_enq_fire = enq_valid & enq_ready;
    w_deq_fire = deq_valid & deq_ready;
    // Output-buffer occupancy one cycle ahead, counting the read in flight;
    // depending on deq_fire here is what sustains one word per cycle.
    w_slots    = {1'b0, r_ocnt} + {2'b00, r_infl} - {2'b00, w_deq_fire};
    reb        = (r_mcnt != '0) && (w_slots < 3'd2);
    w_ob_tail  = r_ocnt - {1'b0, w_deq_fire};
`ifdef BRAM_FIFO_BYPASS_EN
    w_bypass   = w_enq_fire && (r_mcnt == '0) && !r_infl && (w_ob_tail < 2'd2);
`else
    w_bypass   = 1'b0;
`endif
    wea        = w_enq_fire & ~w_bypass;
    w_ob_wr    = r_infl | w_bypass;
    w_ob_word  = r_infl ? dob : enq_data;
    w_mcnt_nxt = r_mcnt + {{ADDR_WIDTH{1'b0}}, wea} - {{ADDR_WIDTH{1'b0}}, reb};
    w_ocnt_nxt = w_ob_tail + {1'b0, w_ob_wr};
    w_count_nxt = (ADDR_WIDTH+2)'(w_mcnt_nxt) + (ADDR_WIDTH+2)'(reb)
                + (ADDR_WIDTH+2)'(w_ocnt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_mcnt  <= '0;
      r_infl  <= 1'b0;
      r_ocnt  <= 2'd0;
      r_ob0   <= '0;
      r_ob1   <= '0;
      r_count <= '0;
    end else begin
      if (wea) r_wp <= f_ptr_inc(r_wp);
      if (reb) r_rp <= f_ptr_inc(r_rp);
      r_mcnt  <= w_mcnt_nxt;
      r_infl  <= reb;
      r_ocnt  <= w_ocnt_nxt;
      r_count <= w_count_nxt;
      // Pop shifts the second entry forward; an empty pop leaves the head as-is.
      if (w_deq_fire && (r_ocnt == 2'd2)) r_ob0 <= r_ob1;
      if (w_ob_wr) begin
        if (w_ob_tail == 2'd0) r_ob0 <= w_ob_word;
        else                   r_ob1 <= w_ob_word;
      end
    end
  end

  a_no_read_empty : assert property (@(posedge clk) disable iff (!rst_n)
    reb |-> (r_mcnt != '0));
  a_no_write_full : assert property (@(posedge clk) disable iff (!rst_n)
    wea |-> (r_mcnt != c_depth));
  a_no_collision  : assert property (@(posedge clk) disable iff (!rst_n)
    (wea && reb) |-> (wr_addra != rd_addrb));
  a_ocnt_range    : assert property (@(posedge clk) disable iff (!rst_n)
    r_ocnt <= 2'd2);

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bram_fifo_ctrl : bram_fifo_ctrl with a BRAM model and a queue scoreboard.
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

  localparam int DW    = 36;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_FIFO_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [DW-1:0] enq_data = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [DW-1:0] deq_data;
  logic          wea;
  logic [AW-1:0] wr_addra;
  logic [DW-1:0] dia;
  logic          reb;
  logic [AW-1:0] rd_addrb;
  logic [DW-1:0] dob;
  logic [AW+1:0] count;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .wea(wea), .wr_addra(wr_addra), .dia(dia),
    .reb(reb), .rd_addrb(rd_addrb), .dob(dob),
    .count(count)
  );

  always #5 clk = ~clk;

  // BRAM with registered read; contents survive reset like the real macro.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wea) mem[wr_addra] <= dia;
    if (reb) dob <= mem[rd_addrb];
  end

  logic [DW-1:0] q[$];
  int            qt[$];
  logic [DW-1:0] deq_log[$];
  int            cyc = 0;
  int            b_cnt = 0, wr_n = 0, rd_n = 0;
  logic          last_enq_fire = 1'b0, last_deq_fire = 1'b0;
  int            checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic          ef, df;
    int            age;
    logic [DW-1:0] exp;
    check("count", 64'(count), 64'(q.size()));
    age = (q.size() > 0) ? cyc - qt[0] : 0;
    if (q.size() == 0)  check("valid_empty", 64'(deq_valid), 64'd0);
    else if (age >= 3)  check("valid_due", 64'(deq_valid), 64'd1);
`ifndef BRAM_FIFO_BYPASS_EN
    else                check("valid_early", 64'(deq_valid), 64'd0);
`endif
    if (q.size() < DEPTH)      check("enq_ready_space", 64'(enq_ready), 64'd1);
    if (q.size() == DEPTH + 2) check("enq_ready_full", 64'(enq_ready), 64'd0);
    ef = enq_valid & enq_ready;
    df = deq_valid & deq_ready;
`ifndef BRAM_FIFO_BYPASS_EN
    check("wea_eq_fire", 64'(wea), 64'(ef));
`endif
    if (reb) begin
      check("reb_nonempty", 64'(b_cnt > 0), 64'd1);
      check("rd_addr", 64'(rd_addrb), 64'(rd_n % DEPTH));
      rd_n++;
    end
    if (wea) begin
      check("wea_fire", 64'(ef), 64'd1);
      check("wea_room", 64'(b_cnt < DEPTH), 64'd1);
      check("wr_addr", 64'(wr_addra), 64'(wr_n % DEPTH));
      check("dia", 64'(dia), 64'(enq_data));
      wr_n++;
    end
    b_cnt += int'(wea) - int'(reb);
    if (df) begin
      check("deq_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp = q.pop_front();
        void'(qt.pop_front());
        check("deq_data", 64'(deq_data), 64'(exp));
      end
      deq_log.push_back(deq_data);
    end
    if (ef) begin
      q.push_back(enq_data);
      qt.push_back(cyc);
    end
    last_enq_fire = ef;
    last_deq_fire = df;
    cyc++;
  endtask

  task automatic tick(input logic v, input logic r, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    enq_valid = v;
    deq_ready = r;
    enq_data  = d;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enq_ready"}, 64'(enq_ready), 64'd1);
    check({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
    check({tag, "_deq_data"},  64'(deq_data),  64'd0);
    check({tag, "_count"},     64'(count),     64'd0);
    check({tag, "_wea"},       64'(wea),       64'd0);
    check({tag, "_reb"},       64'(reb),       64'd0);
    check({tag, "_wr_addra"},  64'(wr_addra),  64'd0);
    check({tag, "_rd_addrb"},  64'(rd_addrb),  64'd0);
    check({tag, "_dia"},       64'(dia),       64'(enq_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, first, t_enq, gaps, stalls;

    #2;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, '0);
      check("idle_wea", 64'(wea), 64'd0);
      check("idle_reb", 64'(reb), 64'd0);
    end

    tick(1'b1, 1'b1, 36'h123456789);
    t_enq = cyc - 1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, '0);
      if (deq_valid && first < 0) begin
        first = cyc - 1;
        check("single_data", 64'(deq_data), 64'h123456789);
      end
    end
    check("single_latency", 64'(first - t_enq), 64'(EXP_LAT));
    check("single_count", 64'(count), 64'd0);

    idx = 0;
    for (int i = 0; i < 20; i++) begin
      tick(idx < 10, 1'b0, DW'(idx));
      if (last_enq_fire) idx++;
    end
    check("full_accepted", 64'(idx), 64'(DEPTH + 2));
    check("full_count", 64'(count), 64'(DEPTH + 2));
    check("full_ready", 64'(enq_ready), 64'd0);
    deq_log.delete();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, '0);
    check("drain_n", 64'(deq_log.size()), 64'(DEPTH + 2));
    for (int i = 0; i < deq_log.size(); i++) check("drain_order", 64'(deq_log[i]), 64'(i));

    idx = 0; first = -1; gaps = 0; stalls = 0;
    deq_log.delete();
    for (int c = 0; c < 1100 && deq_log.size() < 1000; c++) begin
      tick(idx < 1000, 1'b1, DW'(idx));
      if (last_enq_fire) idx++;
      else if (idx < 1000) stalls++;
      if (last_deq_fire) begin
        if (first < 0) first = c;
      end else if (first >= 0) gaps++;
    end
    check("stream_accepted", 64'(idx), 64'd1000);
    check("stream_dequeued", 64'(deq_log.size()), 64'd1000);
    check("stream_first", 64'(first), 64'(EXP_LAT));
    check("stream_gaps", 64'(gaps), 64'd0);
    check("stream_stalls", 64'(stalls), 64'd0);
    if (deq_log.size() == 1000) check("stream_last", 64'(deq_log[999]), 64'd999);

    for (int i = 0; i < 10000; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {4'($urandom()), 32'($urandom())});
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, '0);
    check("random_drained", 64'(count), 64'd0);

    tick(1'b1, 1'b0, 36'h1);
    tick(1'b1, 1'b0, 36'h2);
    tick(1'b1, 1'b0, 36'h3);
    tick(1'b0, 1'b0, '0);
    check("pre_reset_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    q.delete(); qt.delete(); deq_log.delete();
    b_cnt = 0; wr_n = 0; rd_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1'b1, 1'b1, 36'hAA);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, '0);
    check("post_reset_n", 64'(deq_log.size()), 64'd1);
    if (deq_log.size() > 0) check("post_reset_first", 64'(deq_log[0]), 64'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
